// File: rtl/cache_port_arb.sv
// -----------------------------------------------------------------------------
// cache_port_arb
//
// Shares one cache port among N_CH CPU-side request channels. Each accepted
// request makes one pass through IDLE -> GRANT -> RESP -> IDLE:
//   IDLE  : choose a winner among the pending c_req bits and latch a one-hot
//           grant. ARB_MODE=0 is round-robin starting at rr_ptr; ARB_MODE=1
//           is fixed priority, where the lowest index wins.
//   GRANT : present the granted channel's live fields on the m_* port and
//           wait for m_wait=0, then capture m_out.
//   RESP  : hand the captured data to the granted channel for one cycle
//           (c_wait low), then advance rr_ptr past that channel.
//
// Ports
//   clk, rstn            clock; asynchronous active-low reset
//   c_req/c_write        per-channel request and write flag
//   c_addr/c_in/c_type   flattened per-channel fields, channel i at [i*W +: W]
//   c_out/c_wait         flattened per-channel read data and per-channel stall
//   m_req/m_write/m_addr/m_in/m_type   cache-side request (nonzero only in GRANT)
//   m_out/m_wait         cache read data and cache stall
//   busy_o               high whenever the FSM is not in IDLE
//   grant_o              one-hot grant, zero in IDLE
// -----------------------------------------------------------------------------
module cache_port_arb #(
  parameter int N_CH     = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TYPE_W   = 3,
  parameter int ARB_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_CH-1:0]        c_req,
  input  logic [N_CH-1:0]        c_write,
  input  logic [N_CH*ADDR_W-1:0] c_addr,
  input  logic [N_CH*DATA_W-1:0] c_in,
  input  logic [N_CH*TYPE_W-1:0] c_type,
  output logic [N_CH*DATA_W-1:0] c_out,
  output logic [N_CH-1:0]        c_wait,
  output logic                   m_req,
  output logic                   m_write,
  output logic [ADDR_W-1:0]      m_addr,
  output logic [DATA_W-1:0]      m_in,
  output logic [TYPE_W-1:0]      m_type,
  input  logic [DATA_W-1:0]      m_out,
  input  logic                   m_wait,
  output logic                   busy_o,
  output logic [N_CH-1:0]        grant_o
);

  localparam int               PTR_W     = $clog2(N_CH);
  localparam logic [PTR_W:0]   N_CH_P    = (PTR_W+1)'(N_CH);
  localparam logic [PTR_W-1:0] LAST_P    = PTR_W'(N_CH - 1);
  localparam logic [PTR_W-1:0] ZERO_P    = PTR_W'(0);
  localparam logic [PTR_W-1:0] ONE_P     = PTR_W'(1);
  localparam logic [N_CH-1:0]  GNT_LSB_P = N_CH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e              state_q;
  logic [N_CH-1:0]     grant_q;
  logic [PTR_W-1:0]    gidx_q;
  logic [PTR_W-1:0]    rr_ptr_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                m_req_q;
  logic                busy_q;

  logic [PTR_W:0]      sum_s;
  logic [PTR_W-1:0]    cand_s;
  logic                hit_s;
  logic                win_valid_s;
  logic [PTR_W-1:0]    win_idx_s;
  logic [N_CH-1:0]     grant_d;
  logic                in_grant_s;
  logic                in_resp_s;

  // Winner selection. The scan runs from the last candidate down to the
  // first, so the final hit is the first pending channel in search order.
  // That order starts at rr_ptr for round-robin, or at 0 for fixed priority.
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = ZERO_P;
    sum_s       = {(PTR_W+1){1'b0}};
    cand_s      = ZERO_P;
    hit_s       = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      sum_s       = {1'b0, rr_ptr_q} + k[PTR_W:0];
      sum_s       = (sum_s >= N_CH_P) ? (sum_s - N_CH_P) : sum_s;
      cand_s      = (ARB_MODE == 1) ? k[PTR_W-1:0] : sum_s[PTR_W-1:0];
      hit_s       = c_req[cand_s];
      win_valid_s = win_valid_s | hit_s;
      win_idx_s   = hit_s ? cand_s : win_idx_s;
    end
  end

  assign grant_d    = GNT_LSB_P << win_idx_s;
  assign in_grant_s = (state_q == GRANT);
  assign in_resp_s  = (state_q == RESP);

  // Arbitration FSM. It holds the state, the grant, the round-robin pointer,
  // the captured read data, and the registered m_req/busy outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      grant_q  <= {N_CH{1'b0}};
      gidx_q   <= ZERO_P;
      rr_ptr_q <= ZERO_P;
      rdata_q  <= {DATA_W{1'b0}};
      m_req_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid_s) begin
            state_q <= GRANT;
            grant_q <= grant_d;
            gidx_q  <= win_idx_s;
            m_req_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          // The cache side finishes even if the requester dropped c_req.
          if (!m_wait) begin
            state_q <= RESP;
            rdata_q <= m_out;
            m_req_q <= 1'b0;
          end else begin
            state_q <= GRANT;
          end
        end
        RESP: begin
          state_q  <= IDLE;
          grant_q  <= {N_CH{1'b0}};
          busy_q   <= 1'b0;
          rr_ptr_q <= (gidx_q == LAST_P) ? ZERO_P : (gidx_q + ONE_P);
        end
        default: begin
          state_q <= IDLE;
          grant_q <= {N_CH{1'b0}};
          m_req_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_req   = m_req_q;
  assign busy_o  = busy_q;
  assign grant_o = grant_q;

  // Port muxing. The cache port carries the granted channel's live fields
  // only in GRANT. Each channel stalls on its own request except for the
  // one cycle in which it completes in RESP.
  always_comb begin
    m_write = 1'b0;
    m_addr  = {ADDR_W{1'b0}};
    m_in    = {DATA_W{1'b0}};
    m_type  = {TYPE_W{1'b0}};
    c_wait  = c_req;
    c_out   = {(N_CH*DATA_W){1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      m_write = m_write | (in_grant_s & grant_q[i] & c_write[i]);
      m_addr  = m_addr | ({ADDR_W{in_grant_s & grant_q[i]}} & c_addr[i*ADDR_W +: ADDR_W]);
      m_in    = m_in   | ({DATA_W{in_grant_s & grant_q[i]}} & c_in[i*DATA_W +: DATA_W]);
      m_type  = m_type | ({TYPE_W{in_grant_s & grant_q[i]}} & c_type[i*TYPE_W +: TYPE_W]);
      c_wait[i] = c_req[i] & ~(in_resp_s & grant_q[i]);
      c_out[i*DATA_W +: DATA_W] = {DATA_W{in_resp_s & grant_q[i]}} & rdata_q;
    end
  end

endmodule

// File: tb/tb_cache_port_arb.sv
module tb_cache_port_arb;

  logic        clk;
  logic        rstn;
  int          total;
  int          bad;

  // shared stimulus for the two 2-channel instances
  logic [1:0]  req2, wr2;
  logic [63:0] addr2, din2;
  logic [5:0]  type2;
  logic [31:0] m_out_s;
  logic        m_wait_s;

  // 4-channel instance stimulus
  logic [3:0]   req4, wr4;
  logic [127:0] addr4, din4;
  logic [11:0]  type4;

  // round-robin, N_CH=2
  logic [63:0] ra_c_out;
  logic [1:0]  ra_c_wait, ra_grant;
  logic        ra_m_req, ra_m_write, ra_busy;
  logic [31:0] ra_m_addr, ra_m_in;
  logic [2:0]  ra_m_type;

  // fixed priority, N_CH=2
  logic [63:0] fp_c_out;
  logic [1:0]  fp_c_wait, fp_grant;
  logic        fp_m_req, fp_m_write, fp_busy;
  logic [31:0] fp_m_addr, fp_m_in;
  logic [2:0]  fp_m_type;

  // round-robin, N_CH=4
  logic [127:0] q4_c_out;
  logic [3:0]   q4_c_wait, q4_grant;
  logic         q4_m_req, q4_m_write, q4_busy;
  logic [31:0]  q4_m_addr, q4_m_in;
  logic [2:0]   q4_m_type;

  cache_port_arb #(.N_CH(2), .ARB_MODE(0)) u_ra (
    .clk(clk), .rstn(rstn), .c_req(req2), .c_write(wr2), .c_addr(addr2),
    .c_in(din2), .c_type(type2), .c_out(ra_c_out), .c_wait(ra_c_wait),
    .m_req(ra_m_req), .m_write(ra_m_write), .m_addr(ra_m_addr), .m_in(ra_m_in),
    .m_type(ra_m_type), .m_out(m_out_s), .m_wait(m_wait_s), .busy_o(ra_busy),
    .grant_o(ra_grant)
  );

  cache_port_arb #(.N_CH(2), .ARB_MODE(1)) u_fp (
    .clk(clk), .rstn(rstn), .c_req(req2), .c_write(wr2), .c_addr(addr2),
    .c_in(din2), .c_type(type2), .c_out(fp_c_out), .c_wait(fp_c_wait),
    .m_req(fp_m_req), .m_write(fp_m_write), .m_addr(fp_m_addr), .m_in(fp_m_in),
    .m_type(fp_m_type), .m_out(m_out_s), .m_wait(m_wait_s), .busy_o(fp_busy),
    .grant_o(fp_grant)
  );

  cache_port_arb #(.N_CH(4), .ARB_MODE(0)) u_q4 (
    .clk(clk), .rstn(rstn), .c_req(req4), .c_write(wr4), .c_addr(addr4),
    .c_in(din4), .c_type(type4), .c_out(q4_c_out), .c_wait(q4_c_wait),
    .m_req(q4_m_req), .m_write(q4_m_write), .m_addr(q4_m_addr), .m_in(q4_m_in),
    .m_type(q4_m_type), .m_out(m_out_s), .m_wait(m_wait_s), .busy_o(q4_busy),
    .grant_o(q4_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rstn = 1'b0; req2 = 2'b10; req4 = 4'b0101;
    @(negedge clk);
    total++; if (ra_c_wait !== 2'b10) begin bad++; $display("FAIL rst_cwait got=%b exp=%b", ra_c_wait, 2'b10); end
    total++; if (ra_m_req !== 1'b0) begin bad++; $display("FAIL rst_mreq got=%b exp=0", ra_m_req); end
    total++; if (ra_grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b exp=00", ra_grant); end
    total++; if (ra_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", ra_busy); end
    total++; if (ra_c_out !== 64'h0) begin bad++; $display("FAIL rst_cout got=%h exp=0", ra_c_out); end
    total++; if (ra_m_addr !== 32'h0) begin bad++; $display("FAIL rst_maddr got=%h exp=0", ra_m_addr); end
    total++; if (q4_c_wait !== 4'b0101) begin bad++; $display("FAIL rst_q4_cwait got=%b exp=0101", q4_c_wait); end
    req2 = 2'b00; req4 = 4'b0000; rstn = 1'b1;
    @(negedge clk);
    total++; if (ra_busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got=%b exp=0", ra_busy); end
  endtask

  task automatic test_single_read();
    req2 = 2'b01; wr2 = 2'b00; addr2 = {32'h0, 32'h0000_0100};
    din2 = {32'h0, 32'h1234_5678}; type2 = {3'b000, 3'b010};
    m_wait_s = 1'b0; m_out_s = 32'hDEAD_BEEF;
    @(negedge clk); // GRANT
    total++; if (ra_m_req !== 1'b1) begin bad++; $display("FAIL rd_mreq got=%b exp=1", ra_m_req); end
    total++; if (ra_m_addr !== 32'h0000_0100) begin bad++; $display("FAIL rd_maddr got=%h exp=100", ra_m_addr); end
    total++; if (ra_m_in !== 32'h1234_5678) begin bad++; $display("FAIL rd_min got=%h exp=12345678", ra_m_in); end
    total++; if (ra_m_type !== 3'b010) begin bad++; $display("FAIL rd_mtype got=%b exp=010", ra_m_type); end
    total++; if (ra_m_write !== 1'b0) begin bad++; $display("FAIL rd_mwrite got=%b exp=0", ra_m_write); end
    total++; if (ra_grant !== 2'b01) begin bad++; $display("FAIL rd_grant got=%b exp=01", ra_grant); end
    total++; if (ra_busy !== 1'b1) begin bad++; $display("FAIL rd_busy got=%b exp=1", ra_busy); end
    total++; if (ra_c_wait !== 2'b01) begin bad++; $display("FAIL rd_cwait_g got=%b exp=01", ra_c_wait); end
    @(negedge clk); // RESP
    total++; if (ra_c_wait !== 2'b00) begin bad++; $display("FAIL rd_cwait_r got=%b exp=00", ra_c_wait); end
    total++; if (ra_c_out !== {32'h0, 32'hDEAD_BEEF}) begin bad++; $display("FAIL rd_cout got=%h exp=%h", ra_c_out, {32'h0, 32'hDEAD_BEEF}); end
    total++; if (ra_m_req !== 1'b0) begin bad++; $display("FAIL rd_mreq_r got=%b exp=0", ra_m_req); end
    total++; if (ra_m_addr !== 32'h0) begin bad++; $display("FAIL rd_maddr_r got=%h exp=0", ra_m_addr); end
    req2 = 2'b00;
    @(negedge clk); // IDLE
    total++; if (ra_busy !== 1'b0) begin bad++; $display("FAIL rd_busy_i got=%b exp=0", ra_busy); end
    total++; if (ra_grant !== 2'b00) begin bad++; $display("FAIL rd_grant_i got=%b exp=00", ra_grant); end
    total++; if (ra_c_out !== 64'h0) begin bad++; $display("FAIL rd_cout_i got=%h exp=0", ra_c_out); end
  endtask

  task automatic test_rr_contention();
    logic [1:0]  eg;
    logic [31:0] ea;
    logic [63:0] ec;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    addr2 = {32'h0000_0200, 32'h0000_0100}; req2 = 2'b11; m_wait_s = 1'b0;
    for (int n = 0; n < 4; n++) begin
      eg = n[0] ? 2'b10 : 2'b01;
      ea = n[0] ? 32'h0000_0200 : 32'h0000_0100;
      @(negedge clk); // GRANT
      total++; if (ra_grant !== eg) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", n, ra_grant, eg); end
      total++; if (ra_c_wait !== 2'b11) begin bad++; $display("FAIL rr_cwait_g[%0d] got=%b exp=11", n, ra_c_wait); end
      total++; if (ra_m_addr !== ea) begin bad++; $display("FAIL rr_maddr[%0d] got=%h exp=%h", n, ra_m_addr, ea); end
      total++; if (fp_grant !== 2'b01) begin bad++; $display("FAIL fp_grant[%0d] got=%b exp=01", n, fp_grant); end
      m_out_s = 32'hA000_0000 | {30'h0, n[1:0]};
      ec = n[0] ? {m_out_s, 32'h0} : {32'h0, m_out_s};
      @(negedge clk); // RESP
      total++; if (ra_c_wait !== (2'b11 & ~eg)) begin bad++; $display("FAIL rr_cwait_r[%0d] got=%b exp=%b", n, ra_c_wait, 2'b11 & ~eg); end
      total++; if (ra_c_out !== ec) begin bad++; $display("FAIL rr_cout[%0d] got=%h exp=%h", n, ra_c_out, ec); end
      total++; if (fp_c_wait !== 2'b10) begin bad++; $display("FAIL fp_cwait_r[%0d] got=%b exp=10", n, fp_c_wait); end
      @(negedge clk); // IDLE
      total++; if (ra_grant !== 2'b00) begin bad++; $display("FAIL rr_grant_i[%0d] got=%b exp=00", n, ra_grant); end
      total++; if (fp_c_wait[1] !== 1'b1) begin bad++; $display("FAIL fp_cwait1_i[%0d] got=%b exp=1", n, fp_c_wait[1]); end
    end
    req2 = 2'b00;
  endtask

  task automatic test_stall();
    req2 = 2'b10; addr2 = {32'h0000_0300, 32'h0000_0100};
    m_wait_s = 1'b1; m_out_s = 32'h5555_AAAA;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); // GRANT, stalled for cycles 0..4
      total++; if (ra_m_req !== 1'b1) begin bad++; $display("FAIL st_mreq[%0d] got=%b exp=1", k, ra_m_req); end
      total++; if (ra_m_addr !== 32'h0000_0300) begin bad++; $display("FAIL st_maddr[%0d] got=%h exp=300", k, ra_m_addr); end
      total++; if (ra_c_wait !== 2'b10) begin bad++; $display("FAIL st_cwait[%0d] got=%b exp=10", k, ra_c_wait); end
      if (k == 5) m_wait_s = 1'b0;
    end
    @(negedge clk); // RESP
    total++; if (ra_c_wait !== 2'b00) begin bad++; $display("FAIL st_cwait_r got=%b exp=00", ra_c_wait); end
    total++; if (ra_c_out !== {32'h5555_AAAA, 32'h0}) begin bad++; $display("FAIL st_cout got=%h exp=%h", ra_c_out, {32'h5555_AAAA, 32'h0}); end
    req2 = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_grant();
    req2 = 2'b01; m_wait_s = 1'b0; m_out_s = 32'h1111_1111;
    @(negedge clk); // GRANT ch0, rr_ptr moves to 1 after RESP
    total++; if (ra_grant !== 2'b01) begin bad++; $display("FAIL rm_pre_grant got=%b exp=01", ra_grant); end
    @(negedge clk); // RESP
    req2 = 2'b11; m_wait_s = 1'b1;
    @(negedge clk); // IDLE
    @(negedge clk); // GRANT ch1 (rr_ptr=1), stalled
    total++; if (ra_grant !== 2'b10) begin bad++; $display("FAIL rm_grant1 got=%b exp=10", ra_grant); end
    rstn = 1'b0;
    #1;
    total++; if (ra_m_req !== 1'b0) begin bad++; $display("FAIL rm_mreq got=%b exp=0", ra_m_req); end
    total++; if (ra_grant !== 2'b00) begin bad++; $display("FAIL rm_grant got=%b exp=00", ra_grant); end
    total++; if (ra_busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", ra_busy); end
    total++; if (ra_c_wait !== 2'b11) begin bad++; $display("FAIL rm_cwait got=%b exp=11", ra_c_wait); end
    @(negedge clk);
    rstn = 1'b1; m_wait_s = 1'b0;
    @(negedge clk); // re-granted from rr_ptr=0
    total++; if (ra_grant !== 2'b01) begin bad++; $display("FAIL rm_regrant got=%b exp=01", ra_grant); end
    total++; if (ra_m_req !== 1'b1) begin bad++; $display("FAIL rm_remreq got=%b exp=1", ra_m_req); end
    req2 = 2'b00; // requester drops during GRANT; RESP must still occur
    @(negedge clk);
    total++; if (ra_busy !== 1'b1) begin bad++; $display("FAIL drop_busy got=%b exp=1", ra_busy); end
    total++; if (ra_grant !== 2'b01) begin bad++; $display("FAIL drop_grant got=%b exp=01", ra_grant); end
    @(negedge clk);
    total++; if (ra_busy !== 1'b0) begin bad++; $display("FAIL drop_idle got=%b exp=0", ra_busy); end
  endtask

  task automatic test_rr4();
    req4 = 4'b0010; wr4 = 4'b0000; din4 = 128'h0; type4 = 12'h000;
    addr4 = {32'h0000_3300, 32'h0000_2200, 32'h0000_1100, 32'h0000_0000};
    m_wait_s = 1'b0; m_out_s = 32'h4444_0001;
    @(negedge clk); // GRANT ch1
    total++; if (q4_grant !== 4'b0010) begin bad++; $display("FAIL q4_grant_a got=%b exp=0010", q4_grant); end
    total++; if (q4_m_addr !== 32'h0000_1100) begin bad++; $display("FAIL q4_maddr_a got=%h exp=1100", q4_m_addr); end
    @(negedge clk); // RESP ch1 -> rr_ptr=2
    total++; if (q4_c_out !== {64'h0, 32'h4444_0001, 32'h0}) begin bad++; $display("FAIL q4_cout_a got=%h", q4_c_out); end
    req4 = 4'b1010; m_out_s = 32'h4444_0003;
    @(negedge clk); // IDLE
    total++; if (q4_c_wait !== 4'b1010) begin bad++; $display("FAIL q4_cwait_i got=%b exp=1010", q4_c_wait); end
    @(negedge clk); // GRANT ch3
    total++; if (q4_grant !== 4'b1000) begin bad++; $display("FAIL q4_grant_b got=%b exp=1000", q4_grant); end
    total++; if (q4_m_addr !== 32'h0000_3300) begin bad++; $display("FAIL q4_maddr_b got=%h exp=3300", q4_m_addr); end
    @(negedge clk); // RESP ch3
    total++; if (q4_c_wait !== 4'b0010) begin bad++; $display("FAIL q4_cwait_r got=%b exp=0010", q4_c_wait); end
    total++; if (q4_c_out !== {32'h4444_0003, 96'h0}) begin bad++; $display("FAIL q4_cout_b got=%h", q4_c_out); end
    @(negedge clk); // IDLE
    @(negedge clk); // GRANT ch1
    total++; if (q4_grant !== 4'b0010) begin bad++; $display("FAIL q4_grant_c got=%b exp=0010", q4_grant); end
    req4 = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_write_holdoff();
    req2 = 2'b01; wr2 = 2'b01; din2 = {32'h0, 32'hCAFE_F00D};
    type2 = {3'b000, 3'b001}; addr2 = {32'h0000_0200, 32'h0000_0400};
    m_wait_s = 1'b1; m_out_s = 32'h0BAD_0BAD;
    @(negedge clk); // GRANT ch0 write
    total++; if (ra_m_write !== 1'b1) begin bad++; $display("FAIL wr_mwrite got=%b exp=1", ra_m_write); end
    total++; if (ra_m_in !== 32'hCAFE_F00D) begin bad++; $display("FAIL wr_min got=%h exp=cafef00d", ra_m_in); end
    total++; if (ra_m_type !== 3'b001) begin bad++; $display("FAIL wr_mtype got=%b exp=001", ra_m_type); end
    total++; if (ra_m_addr !== 32'h0000_0400) begin bad++; $display("FAIL wr_maddr got=%h exp=400", ra_m_addr); end
    req2 = 2'b11; // ch1 arrives mid-transaction
    @(negedge clk);
    total++; if (ra_c_wait !== 2'b11) begin bad++; $display("FAIL ho_cwait_g got=%b exp=11", ra_c_wait); end
    total++; if (ra_grant !== 2'b01) begin bad++; $display("FAIL ho_grant_g got=%b exp=01", ra_grant); end
    m_wait_s = 1'b0;
    @(negedge clk); // RESP
    total++; if (ra_c_wait !== 2'b10) begin bad++; $display("FAIL ho_cwait_r got=%b exp=10", ra_c_wait); end
    total++; if (ra_m_write !== 1'b0) begin bad++; $display("FAIL wr_mwrite_r got=%b exp=0", ra_m_write); end
    req2 = 2'b10; wr2 = 2'b00;
    @(negedge clk); // IDLE
    total++; if (ra_c_wait !== 2'b10) begin bad++; $display("FAIL ho_cwait_i got=%b exp=10", ra_c_wait); end
    @(negedge clk); // GRANT ch1
    total++; if (ra_grant !== 2'b10) begin bad++; $display("FAIL ho_grant got=%b exp=10", ra_grant); end
    total++; if (ra_m_addr !== 32'h0000_0200) begin bad++; $display("FAIL ho_maddr got=%h exp=200", ra_m_addr); end
    req2 = 2'b00;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    rstn = 1'b0;
    req2 = 2'b00; wr2 = 2'b00; addr2 = 64'h0; din2 = 64'h0; type2 = 6'h00;
    req4 = 4'b0000; wr4 = 4'b0000; addr4 = 128'h0; din4 = 128'h0; type4 = 12'h000;
    m_out_s = 32'h0; m_wait_s = 1'b0;
    test_reset();
    test_single_read();
    test_rr_contention();
    test_stall();
    test_reset_mid_grant();
    test_rr4();
    test_write_holdoff();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_port_arb.md
CACHE_PORT_ARB -- requirements
Module: cache_port_arb

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N_CH, 2, number of CPU-side request channels (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TYPE_W, 3, access-type width (byte/half/word, signed/unsigned).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rstn, in, 1, reset, asynchronous, active-low.
- c_req, in, N_CH, per-channel request.
- c_write, in, N_CH, per-channel write flag.
- c_addr, in, N_CH*ADDR_W, flattened addresses; channel i occupies [i*ADDR_W +: ADDR_W].
- c_in, in, N_CH*DATA_W, flattened write data.
- c_type, in, N_CH*TYPE_W, flattened access types.
- c_out, out, N_CH*DATA_W, flattened read data.
- c_wait, out, N_CH, per-channel stall.
- m_req, out, 1, cache request.
- m_write, out, 1, cache write flag.
- m_addr, out, ADDR_W, cache address.
- m_in, out, DATA_W, cache write data.
- m_type, out, TYPE_W, cache access type.
- m_out, in, DATA_W, cache read data.
- m_wait, in, 1, cache stall.
- busy_o, out, 1, high in any state except IDLE.
- grant_o, out, N_CH, one-hot grant, zero in IDLE.

Function
REQ-003 Handshake (both sides) SHALL be: requester holds req and fields stable; transaction completes in the cycle where req=1 and wait=0.
REQ-004 The FSM SHALL have three states: IDLE, GRANT, RESP.
REQ-005 IDLE: if any c_req bit is set, the arbiter SHALL latch a one-hot grant and go to GRANT; otherwise stay in IDLE.
REQ-006 ARB_MODE=0: the winner SHALL be the first set c_req bit at or after rr_ptr, wrapping from N_CH-1 to 0.
REQ-007 ARB_MODE=1: the winner SHALL be the lowest-index set c_req bit; rr_ptr is unused.
REQ-008 GRANT: m_req SHALL be 1 and m_write/m_addr/m_in/m_type SHALL equal the granted channel's live inputs.
REQ-009 Outside GRANT: m_req SHALL be 0 and the other m_* outputs SHALL be 0.
REQ-010 GRANT: when m_wait=0, the arbiter SHALL register m_out into rdata_q and go to RESP; while m_wait=1 it stays in GRANT.
REQ-011 RESP: c_wait[g]=0 and c_out[g]=rdata_q for the granted channel g for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-012 RESP: rr_ptr SHALL become (g+1) mod N_CH.
REQ-013 c_wait[i] SHALL equal c_req[i] for every channel not in RESP, including the granted channel during GRANT, which stays 1.
REQ-014 c_out for non-completing channels SHALL be 0.
REQ-015 Latency: request sampled in IDLE at cycle t → m_req at t+1 → completion to CPU one cycle after the m_wait=0 cycle. With a zero-wait cache, the CPU sees c_wait=0 at t+2.
REQ-016 If the granted c_req drops during GRANT, the downstream transaction SHALL still complete and RESP SHALL still occur; the data is discarded by the requester.
REQ-017 Requests arriving in GRANT or RESP SHALL be held off (c_wait=1) and arbitrated in the next IDLE.
REQ-018 A channel completing in RESP may re-request in the following IDLE; under round-robin it SHALL lose to any other pending channel.
REQ-019 Write transactions SHALL follow the same FSM path; c_out of the completing channel during RESP is rdata_q, which is don't-care for writes.

Reset
REQ-020 rstn low SHALL asynchronously force: state=IDLE, rr_ptr=0, grant=0, rdata_q=0, m_req=0, all c_wait equal to c_req, c_out=0, busy_o=0, grant_o=0.
REQ-021 Reset asserted mid-GRANT SHALL abandon the transaction; after release the channel re-arbitrates normally.

Verification
REQ-022 Single read, N_CH=2: c_req=01, addr 0x100, cache returns 0xDEADBEEF with m_wait=0 in its first GRANT cycle → c_wait[0]=0, c_out[0]=0xDEADBEEF two cycles after request.
REQ-023 Round-robin contention: c_req=11 held continuously → grants alternate 0,1,0,1; no channel granted twice consecutively.
REQ-024 ARB_MODE=1, c_req=11 held → channel 0 granted every IDLE; channel 1 c_wait stays 1.
REQ-025 Cache stall: m_wait=1 for 5 GRANT cycles → m_req/m_addr stable for 6 cycles; c_wait[g] stays 1 until RESP.
REQ-026 Reset mid-GRANT: rstn low for 1 cycle → m_req=0 and grant_o=0 immediately; a held c_req is re-granted after release with rr_ptr=0.
REQ-027 N_CH=4, c_req=1010 with rr_ptr=2 → channel 3 granted first, then channel 1.
